// File: rtl/pwm_audio_sink.sv
// pwm_audio_sink: FIFO-buffered sample sink playing one sample per 2**WIDTH-cycle PWM period.
// Define PWM_AUDIO_HOLD_LAST_EN to repeat the last duty on underrun instead of midscale.
module pwm_audio_sink #(
  parameter int WIDTH      = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          enable,
  input  logic [WIDTH-1:0]              sample_in,
  input  logic                          sample_valid,
  output logic                          sample_ready,
  output logic                          pwm_out,
  output logic                          period_start,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          underrun,
  input  logic                          underrun_clr
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [WIDTH-1:0] MID = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] CMAX = '1;
  logic [WIDTH-1:0] mem [FIFO_DEPTH];
  logic [WIDTH-1:0] cnt, duty, nxt_cnt, nxt_duty, fallback;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic run, boundary, push, pop, empty;
  assign sample_ready = rst_n & (fifo_level != (AW+1)'(FIFO_DEPTH));
  always_comb begin
    empty    = fifo_level == '0;
    boundary = enable & (~run | (cnt == CMAX));
    push     = sample_valid & sample_ready;
    pop      = boundary & ~empty;
`ifdef PWM_AUDIO_HOLD_LAST_EN
    fallback = duty;
`else
    fallback = MID;
`endif
    nxt_duty = boundary ? (empty ? fallback : mem[rd_ptr]) : duty;
    nxt_cnt  = boundary ? '0 : cnt + 1'b1;
  end
  // the first enabled cycle after idle is itself a boundary, so run tracks last cycle's enable
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      run          <= 1'b0;
      cnt          <= '0;
      duty         <= MID;
      pwm_out      <= 1'b0;
      period_start <= 1'b0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      fifo_level   <= '0;
      underrun     <= 1'b0;
    end else begin
      run          <= enable;
      cnt          <= enable ? nxt_cnt : '0;
      duty         <= nxt_duty;
      pwm_out      <= enable & (nxt_cnt < nxt_duty);
      period_start <= boundary;
      wr_ptr       <= push ? wr_ptr + 1'b1 : wr_ptr;
      rd_ptr       <= pop ? rd_ptr + 1'b1 : rd_ptr;
      fifo_level   <= fifo_level + (AW+1)'(push) - (AW+1)'(pop);
      underrun     <= (boundary & empty) | (underrun & ~underrun_clr);
    end
  end
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= sample_in;
endmodule
